hd_demuxb2_stream: RTL

// - Inverting 1:2 stream demultiplexer: the steering counterpart of the inverting 2:1 mux cell HDMUXB2.
// - Each accepted beat is inverted and routed by SL to output 0 or output 1. Feeding both outputs back

---
 rtl/hd_demuxb2_stream_pkg.sv | 10 +
 rtl/hd_demuxb2_stream_if.sv | 32 +++
 rtl/hd_demuxb2_fifo.sv | 67 ++++++
 rtl/hd_demuxb2_stream.sv | 65 ++++++
 4 files changed

// File: rtl/hd_demuxb2_stream_pkg.sv
// Shared constants for the inverting 1:2 stream demux: default sizes and route encodings.
package hd_demuxb2_stream_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 8;

  // Route select encodings: SL low steers to Z0, SL high steers to Z1.
  localparam logic SL_Z0 = 1'b0;
  localparam logic SL_Z1 = 1'b1;
endpackage

// File: rtl/hd_demuxb2_stream_if.sv
// Stream bundle: one input stream, two output streams and the per-output beat counters.
interface hd_demuxb2_stream_if
  import hd_demuxb2_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);
  logic [WIDTH-1:0] DIN;
  logic             SL;
  logic             IN_VLD;
  logic             IN_RDY;
  logic [WIDTH-1:0] Z0;
  logic             Z0_VLD;
  logic             Z0_RDY;
  logic [WIDTH-1:0] Z1;
  logic             Z1_VLD;
  logic             Z1_RDY;
  logic [CNT_W-1:0] CNT0;
  logic [CNT_W-1:0] CNT1;

  // Producer/consumer side (drives the input stream, takes the outputs).
  modport master (
    output DIN, SL, IN_VLD, Z0_RDY, Z1_RDY,
    input  IN_RDY, Z0, Z0_VLD, Z1, Z1_VLD, CNT0, CNT1
  );

  // Demux side.
  modport slave (
    input  DIN, SL, IN_VLD, Z0_RDY, Z1_RDY,
    output IN_RDY, Z0, Z0_VLD, Z1, Z1_VLD, CNT0, CNT1
  );
endinterface

// File: rtl/hd_demuxb2_fifo.sv
// Small synchronous FIFO with async-high reset and synchronous flush; head is a storage read.
module hd_demuxb2_fifo
  import hd_demuxb2_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             vld,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        do_push, do_pop;

  assign vld  = (cnt_q != '0);
  assign full = (cnt_q == CW'(DEPTH));
  assign dout = mem_q[rd_q];

  // Pointer/count update; a pop on an empty FIFO and a push into a full one are dropped,
  // and a flush overrides both.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_push = push & ~full;
    do_pop  = pop & vld;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + PW'(1);
      end
      if (do_pop) rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // State registers; reset clears storage too so the head reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/hd_demuxb2_stream.sv
// Inverting 1:2 stream demux: each accepted beat is inverted and queued on the output picked by SL.
module hd_demuxb2_stream
  import hd_demuxb2_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                CK,
  input logic                RST,
  input logic                CLR,
  hd_demuxb2_stream_if.slave bus
);
  logic [1:0]                  full, vld, push, pop;
  logic [1:0][WIDTH-1:0]       dout;
  logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic                        accept;
  logic [WIDTH-1:0]            din_n;

  // Ready looks only at the selected FIFO's fullness, never at the consumers' ready.
  assign bus.IN_RDY = ~RST & ~CLR & ~full[bus.SL];
  assign accept     = bus.IN_VLD & bus.IN_RDY;
  assign push[0]    = accept & (bus.SL == SL_Z0);
  assign push[1]    = accept & (bus.SL == SL_Z1);
  assign pop[0]     = bus.Z0_RDY;
  assign pop[1]     = bus.Z1_RDY;
  assign din_n      = ~bus.DIN;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    hd_demuxb2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk  (CK),
      .rst  (RST),
      .clr  (CLR),
      .push (push[g]),
      .din  (din_n),
      .pop  (pop[g]),
      .dout (dout[g]),
      .vld  (vld[g]),
      .full (full[g])
    );
  end

  assign bus.Z0     = dout[0];
  assign bus.Z1     = dout[1];
  assign bus.Z0_VLD = vld[0];
  assign bus.Z1_VLD = vld[1];
  assign bus.CNT0   = cnt_q[0];
  assign bus.CNT1   = cnt_q[1];

  // Per-output push counters; wrap freely, cleared by flush.
  always_comb begin
    cnt_d = cnt_q;
    if (CLR) cnt_d = '0;
    else begin
      for (int i = 0; i < 2; i++)
        if (push[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule
